// File: rtl/ex_decode_pkg.sv
// Shared opcode/funct constants, EX control word layout and payload type for the EX decode stage.
package ex_decode_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned ALUOP_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_R  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_IL = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_S  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_B  = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_UA = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_IJ = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_IE = 7'b1110011;
  localparam logic [OPCODE_W-1:0] OP_U  = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_J  = 7'b1101111;

  localparam logic [FUNCT7_W-1:0] F7_BASE   = 7'h00;
  localparam logic [FUNCT7_W-1:0] F7_ALT    = 7'h20;
  localparam logic [FUNCT7_W-1:0] F7_MULDIV = 7'h01;

  // EX control word layout
  localparam int unsigned EXOP_W      = 16;
  localparam int unsigned BOP_LSB     = 13;
  localparam int unsigned AOP_LSB     = 9;
  localparam int unsigned MOP_LSB     = 6;
  localparam int unsigned SRCA_BIT    = 5;
  localparam int unsigned SRCB_BIT    = 4;
  localparam int unsigned MDEN_BIT    = 3;
  localparam int unsigned ALUEN_BIT   = 2;
  localparam int unsigned BREN_BIT    = 1;
  localparam int unsigned WORKEN_BIT  = 0;

  localparam logic [ALUOP_W-1:0] ALUOP_INVALID = 4'b1111;

  // Decoded payload carried through output register and skid buffer
  typedef struct packed {
    logic [EXOP_W-1:0] exop;
    logic              illegal;
  } dec_t;

  // ALU op for R-type style encodings: alternate bit selects sub/sra
  function automatic logic [ALUOP_W-1:0] alu_op_of(input logic alt, input logic [FUNCT3_W-1:0] f3);
    return {alt, f3};
  endfunction

endpackage

// File: rtl/ex_decode_comb.sv
// Purely combinational opcode/funct3/funct7 to EX control word decode table.
module ex_decode_comb
  import ex_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FUNCT3_W-1:0] i_funct3,
  input  logic [FUNCT7_W-1:0] i_funct7,
  output logic [EXOP_W-1:0]   o_exop_c,
  output logic                o_illegal_c
);

  logic [EXOP_W-1:0] w_exop;
  logic              w_illegal;

  // Decode table; branchOp always mirrors funct3, aluOp defaults to invalid
  always_comb begin
    w_exop                        = '0;
    w_illegal                     = 1'b0;
    w_exop[BOP_LSB +: FUNCT3_W]   = i_funct3;
    w_exop[AOP_LSB +: ALUOP_W]    = ALUOP_INVALID;
    case (i_opcode)
      OP_R: begin
        w_exop[WORKEN_BIT] = 1'b1;
        w_exop[ALUEN_BIT]  = 1'b1;
        if (i_funct7 == F7_BASE) begin
          w_exop[AOP_LSB +: ALUOP_W] = alu_op_of(1'b0, i_funct3);
        end else if (i_funct7 == F7_ALT) begin
          w_exop[AOP_LSB +: ALUOP_W] = alu_op_of(1'b1, i_funct3);
        end else if ((i_funct7 == F7_MULDIV) && ENABLE_M) begin
          w_exop[MDEN_BIT]             = 1'b1;
          w_exop[ALUEN_BIT]            = 1'b0;
          w_exop[MOP_LSB +: FUNCT3_W]  = i_funct3;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_I: begin
        w_exop[WORKEN_BIT] = 1'b1;
        w_exop[ALUEN_BIT]  = 1'b1;
        w_exop[SRCB_BIT]   = 1'b1;
        if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
          // shifts reuse funct7 to pick logical vs arithmetic
          if (i_funct7 == F7_BASE) begin
            w_exop[AOP_LSB +: ALUOP_W] = alu_op_of(1'b0, i_funct3);
          end else if (i_funct7 == F7_ALT) begin
            w_exop[AOP_LSB +: ALUOP_W] = alu_op_of(1'b1, i_funct3);
          end else begin
            w_illegal = 1'b1;
          end
        end else begin
          w_exop[AOP_LSB +: ALUOP_W] = alu_op_of(1'b0, i_funct3);
        end
      end
      OP_IL, OP_S: begin
        w_exop[WORKEN_BIT]         = 1'b1;
        w_exop[ALUEN_BIT]          = 1'b1;
        w_exop[SRCB_BIT]           = 1'b1;
        w_exop[AOP_LSB +: ALUOP_W] = '0;
      end
      OP_B: begin
        w_exop[WORKEN_BIT] = 1'b1;
        w_exop[BREN_BIT]   = 1'b1;
      end
      OP_UA: begin
        w_exop[WORKEN_BIT]         = 1'b1;
        w_exop[ALUEN_BIT]          = 1'b1;
        w_exop[SRCA_BIT]           = 1'b1;
        w_exop[SRCB_BIT]           = 1'b1;
        w_exop[AOP_LSB +: ALUOP_W] = '0;
      end
      OP_IJ, OP_IE, OP_U, OP_J: begin
        w_illegal = 1'b0;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign o_exop_c    = w_exop;
  assign o_illegal_c = w_illegal;

endmodule

// File: rtl/ex_decode_stage.sv
// Registered EX decode stage: output register plus one-entry skid buffer, flush, illegal counter.
module ex_decode_stage
  import ex_decode_pkg::*;
#(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [FUNCT3_W-1:0] in_funct3,
  input  logic [FUNCT7_W-1:0] in_funct7,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXOP_W-1:0]   out_exop,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag,
  output logic [CNT_W-1:0]    illegal_cnt
);

  dec_t             w_dec;
  logic             w_accept;
  logic             w_out_free;
  logic             w_skid_load;

  logic             r_out_valid;
  dec_t             r_out;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  dec_t             r_skid;
  logic [TAG_W-1:0] r_skid_tag;
  logic [CNT_W-1:0] r_illegal_cnt;

  ex_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .i_opcode    (in_opcode),
    .i_funct3    (in_funct3),
    .i_funct7    (in_funct7),
    .o_exop_c    (w_dec.exop),
    .o_illegal_c (w_dec.illegal)
  );

  assign w_accept    = in_valid & ~r_skid_valid & ~flush;
  assign w_out_free  = ~r_out_valid | out_ready;
  assign w_skid_load = w_accept & r_out_valid & ~out_ready;

  // Output valid: refills from skid first, then from the input; flush empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid <= r_skid_valid | w_accept;
    end
  end

  // Output payload: holds while stalled, older skid entry wins over the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_tag <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out     <= r_skid;
        r_out_tag <= r_skid_tag;
      end else if (w_accept) begin
        r_out     <= w_dec;
        r_out_tag <= in_tag;
      end
    end
  end

  // Skid valid: set when an accept meets a stalled output, cleared on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (out_ready) begin
        r_skid_valid <= 1'b0;
      end
    end else if (w_skid_load) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Skid payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid     <= '0;
      r_skid_tag <= '0;
    end else if (w_skid_load) begin
      r_skid     <= w_dec;
      r_skid_tag <= in_tag;
    end
  end

  // Saturating count of accepted illegal encodings; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_accept && w_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_exop    = r_out.exop;
  assign out_illegal = r_out.illegal;
  assign out_tag     = r_out_tag;
  assign illegal_cnt = r_illegal_cnt;

endmodule
